myproject_dot_acc: RTL and testbench

MYPROJECT_DOT_ACC -- requirements
Module: myproject_dot_acc

---
 rtl/myproject_dot_acc.sv | 112 +++++++++++
 tb/tb_myproject_dot_acc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/myproject_dot_acc.sv
// Streaming dot-product accumulator: sums LEN signed products, then emits one
// round-half-up, saturated result through a valid/ready handshake.
module myproject_dot_acc #(
    parameter int PROD_WIDTH = 36,
    parameter int ACC_WIDTH  = 44,
    parameter int LEN        = 64,
    parameter int SHIFT      = 18,
    parameter int OUT_WIDTH  = 18
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [PROD_WIDTH-1:0] din_data,
    input  logic                 din_valid,
    output logic                 din_ready,
    output logic [OUT_WIDTH-1:0] dout_data,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 dout_ovf
);

    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [PROD_WIDTH-1:0]   din_s;
    logic signed [ACC_WIDTH-1:0]    din_ext;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [ACC_WIDTH:0]      sum_x;
    logic signed [ACC_WIDTH:0]      r;
    logic [ACC_WIDTH-OUT_WIDTH+1:0] upper;
    logic [OUT_WIDTH-1:0]           sat;
    logic                           ovf;
    logic [CNT_W-1:0]               cnt;
    logic                           xfer;
    logic                           last;

    assign din_s   = din_data;
    assign din_ext = ACC_WIDTH'(din_s);
    assign sum     = acc + din_ext;
    assign xfer    = din_valid & din_ready;
    assign last    = (cnt == CNT_W'(LEN - 1));

    // One extra bit of headroom so the rounding constant can never wrap the sum.
    assign sum_x = (ACC_WIDTH + 1)'(sum);

    if (SHIFT > 0) begin : g_round
        localparam logic signed [ACC_WIDTH:0] HALF = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
        assign r = (sum_x + HALF) >>> SHIFT;
    end else begin : g_noround
        assign r = sum_x;
    end

    // r fits the output only when every bit from the output sign bit upward agrees.
    assign upper = r[ACC_WIDTH:OUT_WIDTH-1];
    assign ovf   = !((&upper) || !(|upper));
    assign sat   = !ovf ? r[OUT_WIDTH-1:0] :
                   r[ACC_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                  {1'b0, {(OUT_WIDTH-1){1'b1}}};

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_ACC;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_ACC:  if (xfer && last) state_next = ST_OUT;
            ST_OUT:  if (dout_ready)   state_next = ST_ACC;
            default: state_next = ST_ACC;
        endcase
    end

    always_comb begin
        din_ready = (state == ST_ACC);
    end

    // The handshake edge only drops valid; din_ready is low then, so no product lands.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc        <= '0;
            cnt        <= '0;
            dout_data  <= '0;
            dout_ovf   <= 1'b0;
            dout_valid <= 1'b0;
        end else if (xfer) begin
            if (last) begin
                acc        <= '0;
                cnt        <= '0;
                dout_data  <= sat;
                dout_ovf   <= ovf;
                dout_valid <= 1'b1;
            end else begin
                acc <= sum;
                cnt <= cnt + CNT_W'(1);
            end
        end else if ((state == ST_OUT) && dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_myproject_dot_acc.sv
// Directed bench for myproject_dot_acc with a group-level reference model that
// checks the outputs every cycle, plus literal expectations for each scenario.
module tb_myproject_dot_acc;

    localparam int PROD_WIDTH = 36;
    localparam int ACC_WIDTH  = 44;
    localparam int LEN        = 4;
    localparam int SHIFT      = 2;
    localparam int OUT_WIDTH  = 8;

    logic                         clk;
    logic                         rst_n;
    logic signed [PROD_WIDTH-1:0] din_data;
    logic                         din_valid;
    logic                         din_ready;
    logic signed [OUT_WIDTH-1:0]  dout_data;
    logic                         dout_valid;
    logic                         dout_ready;
    logic                         dout_ovf;

    int checks = 0;
    int errors = 0;

    myproject_dot_acc #(
        .PROD_WIDTH(PROD_WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .LEN       (LEN),
        .SHIFT     (SHIFT),
        .OUT_WIDTH (OUT_WIDTH)
    ) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .din_data  (din_data),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .dout_data (dout_data),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_ovf  (dout_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a group of LEN products becomes one rounded, clipped result.
    function automatic void modelResult(input longint s, output longint d, output longint o);
        longint r;
        longint hi;
        longint lo;
        hi = (longint'(1) << (OUT_WIDTH - 1)) - 1;
        lo = -(longint'(1) << (OUT_WIDTH - 1));
        r  = (s + (longint'(1) << (SHIFT - 1))) >>> SHIFT;
        o  = 0;
        d  = r;
        if (r > hi) begin d = hi; o = 1; end
        if (r < lo) begin d = lo; o = 1; end
    endfunction

    longint grp[$];
    bit     pending = 1'b0;
    longint expData = 0;
    longint expOvf  = 0;

    // Inputs only move just after a rising edge, so the falling edge sees a settled cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                grp.delete();
                pending = 1'b0;
                chk("reset_valid", dout_valid, 0);
                chk("reset_ready", din_ready, 1);
                chk("reset_data", dout_data, 0);
                chk("reset_ovf", dout_ovf, 0);
            end else begin
                chk("model_valid", dout_valid, pending);
                chk("model_ready", din_ready, !pending);
                if (pending) begin
                    chk("model_data", dout_data, expData);
                    chk("model_ovf", dout_ovf, expOvf);
                end
                if (pending) begin
                    if (dout_ready) pending = 1'b0;
                end else if (din_valid) begin
                    grp.push_back(longint'(din_data));
                    if (grp.size() == LEN) begin
                        longint s;
                        s = 0;
                        foreach (grp[k]) s += grp[k];
                        modelResult(s, expData, expOvf);
                        pending = 1'b1;
                        grp.delete();
                    end
                end
            end
        end
    end

    task automatic sendOne(input longint p);
        int waited;
        waited = 0;
        din_valid = 1'b1;
        din_data  = PROD_WIDTH'(p);
        forever begin
            @(negedge clk);
            if (din_ready) break;
            waited++;
            if (waited > 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL send_timeout: got din_ready=0 for %0d cycles, expected 1", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic applyStimulus(input longint p0, input longint p1, input longint p2,
                                 input longint p3, input bit gaps);
        longint p[4];
        p = '{p0, p1, p2, p3};
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    din_valid = 1'b0;
                    din_data  = PROD_WIDTH'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            sendOne(p[i]);
        end
    endtask

    task automatic checkOutput(input longint eData, input longint eOvf, input int holdCycles);
        @(negedge clk);
        chk("latency_valid", dout_valid, 1);
        chk("result_data", dout_data, eData);
        chk("result_ovf", dout_ovf, eOvf);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            din_valid = 1'b1;
            din_data  = 36'sd99;
            @(negedge clk);
            chk("hold_ready", din_ready, 0);
            chk("hold_data", dout_data, eData);
        end
        @(posedge clk);
        #1;
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        din_valid  = 1'b0;
        @(negedge clk);
        chk("post_hs_ready", din_ready, 1);
        chk("post_hs_valid", dout_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        din_valid  = 1'b0;
        din_data   = '0;
        dout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(1, 2, 3, 4, 1'b0);
        checkOutput(3, 0, 0);
        applyStimulus(-1, -1, -1, -2, 1'b0);
        checkOutput(-1, 0, 0);
        applyStimulus(2, 0, 0, 0, 1'b0);
        checkOutput(1, 0, 0);
        applyStimulus(200, 200, 200, 200, 1'b0);
        checkOutput(127, 1, 0);
        applyStimulus(-200, -200, -200, -200, 1'b0);
        checkOutput(-128, 1, 0);

        applyStimulus(5, 6, 7, 8, 1'b0);
        checkOutput(7, 0, 5);
        applyStimulus(1, 2, 3, 4, 1'b0);
        checkOutput(3, 0, 0);

        sendOne(100);
        sendOne(100);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midgroup_rst_ready", din_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1, 1, 1, 1, 1'b0);
        checkOutput(1, 0, 0);

        applyStimulus(1, 2, 3, 4, 1'b1);
        checkOutput(3, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
